// File: rtl/aes_arb_pkg.sv
// rtl/aes_arb_pkg.sv - shared types and constants for the two-requester AES arbiter
package aes_arb_pkg;

  localparam int NUM_REQ = 2;
  localparam int AES_W   = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/aes_arb_rr.sv
// rtl/aes_arb_rr.sv - two-way round-robin grant selection (combinational)
module aes_arb_rr
  import aes_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid,
  input  logic               last_grant,
  output logic [NUM_REQ-1:0] grant
);

  // A lone requester wins outright; on a tie the one not served last wins.
  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/aes_arbiter.sv
// rtl/aes_arbiter.sv - shares one AES engine between two requesters; optional timeout via AES_ARB_TIMEOUT_EN
module aes_arbiter
  import aes_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  input  logic [NUM_REQ-1:0][AES_W-1:0]   req_key_i,
  input  logic [NUM_REQ-1:0][AES_W-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]              rsp_valid_o,
  input  logic [NUM_REQ-1:0]              rsp_ready_i,
  output logic [AES_W-1:0]                rsp_data_o,
  output logic                            rsp_err_o,
  output logic                            eng_start_o,
  output logic [AES_W-1:0]                eng_key_o,
  output logic [AES_W-1:0]                eng_plain_text_o,
  input  logic [AES_W-1:0]                eng_cipher_text_i,
  input  logic                            eng_done_i,
  output logic                            busy_o
);

  arb_state_e         state_q, state_d;
  logic               last_grant_q;
  logic               id_q;
  logic [AES_W-1:0]   key_q, data_q, result_q;
  logic [NUM_REQ-1:0] grant;
  logic               req_hs, rsp_hs, timeout_hit;

  aes_arb_rr u_rr (
    .valid      (req_valid_i),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // grant is always a subset of req_valid_i, so a non-zero grant in IDLE is the handshake.
  assign req_hs = (state_q == ST_IDLE) && (grant != '0);
  assign rsp_hs = (state_q == ST_RESP) && rsp_ready_i[id_q];

`ifdef AES_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_q;
  logic             err_q;

  assign timeout_hit = (state_q == ST_WAIT) && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rsp_err_o   = err_q;

  // Counts WAIT cycles; cleared in ISSUE so every transaction starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else if (state_q == ST_ISSUE) begin
      wait_cnt_q <= '0;
    end else if (state_q == ST_WAIT) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  // Error flag: done wins over a simultaneous timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state_q == ST_WAIT) begin
      if (eng_done_i) begin
        err_q <= 1'b0;
      end else if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  logic timeout_unused;

  // TIMEOUT_CYCLES has no effect in this build; WAIT lasts until the engine finishes.
  assign timeout_unused = (TIMEOUT_CYCLES > 0);
  assign timeout_hit    = 1'b0;
  assign rsp_err_o      = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; eng_done_i is only looked at in WAIT.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (req_hs) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (eng_done_i || timeout_hit) state_d = ST_RESP;
      ST_RESP:  if (rsp_hs) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Payload capture at the request handshake, result capture at the end of WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      key_q        <= '0;
      data_q       <= '0;
      result_q     <= '0;
    end else begin
      if (req_hs) begin
        last_grant_q <= grant[1];
        id_q         <= grant[1];
        key_q        <= req_key_i[grant[1]];
        data_q       <= req_data_i[grant[1]];
      end
      if (state_q == ST_WAIT) begin
        if (eng_done_i) begin
          result_q <= eng_cipher_text_i;
        end else if (timeout_hit) begin
          result_q <= '0;
        end
      end
    end
  end

  // Output decode; req_ready_o is also held low while rst_n is asserted.
  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    if ((state_q == ST_IDLE) && rst_n) begin
      req_ready_o = grant;
    end
    if (state_q == ST_RESP) begin
      rsp_valid_o[id_q] = 1'b1;
    end
    eng_start_o = (state_q == ST_ISSUE);
    busy_o      = (state_q != ST_IDLE);
  end

  assign eng_key_o        = key_q;
  assign eng_plain_text_o = data_q;
  assign rsp_data_o       = result_q;

endmodule

// File: doc/aes_arbiter.md
AES_ARBITER -- requirements
Module: aes_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 64: the maximum number of WAIT-state cycles before abort; used only when AES_ARB_TIMEOUT_EN is defined.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port req_valid_i, input, [1:0]: per-requester request valid.
REQ-005 The block SHALL have port req_ready_o, output, [1:0]: per-requester request accept.
REQ-006 The block SHALL have port req_key_i, input, [1:0][127:0]: per-requester AES key.
REQ-007 The block SHALL have port req_data_i, input, [1:0][127:0]: per-requester plaintext.
REQ-008 The block SHALL have port rsp_valid_o, output, [1:0]: per-requester response valid.
REQ-009 The block SHALL have port rsp_ready_i, input, [1:0]: per-requester response accept.
REQ-010 The block SHALL have port rsp_data_o, output, 128 bits: ciphertext, shared by both requesters.
REQ-011 The block SHALL have port rsp_err_o, output, 1 bit: timeout flag, qualified by rsp_valid_o.
REQ-012 The block SHALL have port eng_start_o, output, 1 bit: engine start pulse.
REQ-013 The block SHALL have port eng_key_o, output, 128 bits: engine key.
REQ-014 The block SHALL have port eng_plain_text_o, output, 128 bits: engine plaintext.
REQ-015 The block SHALL have port eng_cipher_text_i, input, 128 bits: engine result.
REQ-016 The block SHALL have port eng_done_i, input, 1 bit: engine completion.
REQ-017 The block SHALL have port busy_o, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-018 The block SHALL implement the states IDLE, ISSUE, WAIT and RESP.
REQ-019 IDLE grant: if exactly one requester is valid, it wins; if both are valid, the requester that is not last_grant wins. req_ready_o SHALL be one-hot on the winner and SHALL be 0 in every other state.
REQ-020 An IDLE handshake SHALL latch key, data and the grant id, update last_grant to the winner, and move to ISSUE on the next cycle.
REQ-021 ISSUE SHALL assert eng_start_o for exactly one cycle, then move to WAIT.
REQ-022 eng_key_o and eng_plain_text_o SHALL drive the latched registers and stay stable from ISSUE until the block leaves WAIT.
REQ-023 eng_done_i SHALL be sampled only in WAIT; assertions in any other state SHALL be ignored.
REQ-024 eng_done_i in WAIT SHALL capture eng_cipher_text_i and set err to 0, then move to RESP.
REQ-025 RESP SHALL assert rsp_valid_o[id] only, with rsp_data_o and rsp_err_o held stable until rsp_ready_i[id]=1; it SHALL then return to IDLE.
REQ-026 rsp_ready_i on the non-granted bit SHALL be ignored.
REQ-027 Minimum latency SHALL be: request handshake at cycle 0, eng_start_o at cycle 1, rsp_valid_o at cycle D+2 for eng_done_i D cycles after start.
REQ-028 A new grant SHALL occur no earlier than the cycle after the RESP handshake.
REQ-029 A requester that drops req_valid_i before its grant SHALL receive nothing; no request SHALL be queued.

Reset
REQ-030 Asserting rst_n low SHALL asynchronously force: state IDLE; last_grant 1, so requester 0 wins the first tie; all payload, result and err registers 0; and outputs req_ready_o=0, rsp_valid_o=0, eng_start_o=0, busy_o=0, rsp_data_o=0, rsp_err_o=0.
REQ-031 Reset mid-operation SHALL abandon the transaction with no response; the engine is reset from the same rst_n.

Configuration
REQ-032 With AES_ARB_TIMEOUT_EN defined, a WAIT-cycle counter SHALL clear on entry to WAIT.
REQ-033 With AES_ARB_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES without eng_done_i SHALL move to RESP with rsp_data_o=0 and rsp_err_o=1.
REQ-034 With AES_ARB_TIMEOUT_EN defined, eng_done_i in the same cycle the counter hits the limit SHALL count as success.
REQ-035 Without AES_ARB_TIMEOUT_EN, the block SHALL contain no counter, rsp_err_o SHALL be constant 0, and WAIT SHALL persist until eng_done_i.

Structure
REQ-036 A shared package aes_arb_pkg SHALL hold the state enum, NUM_REQ=2, and the width constant AES_W=128.
REQ-037 Grant selection SHALL live in a combinational sub-module aes_arb_rr (inputs valid[1:0] and last_grant; output one-hot grant), instantiated once.

Verification
REQ-038 Single request: requester 0 valid with key=000102…0F and data=00112233…FF; engine model gives done 10 cycles after start -> eng_start_o at cycle 1, rsp_valid_o[0] at cycle 12, data equal to the model output, err=0.
REQ-039 Tie after reset: both requesters valid continuously -> grant order 0,1,0,1 over 4 transactions, with no overlap of busy periods.
REQ-040 Response backpressure: rsp_ready_i[1] held low for 20 cycles -> rsp_valid_o[1] and rsp_data_o stable throughout, req_ready_o=0, and no second eng_start_o.
REQ-041 Spurious done: eng_done_i pulsed in IDLE and in the ISSUE cycle -> no state change and no response.
REQ-042 Timeout (macro on, TIMEOUT_CYCLES=8): engine never asserts done -> RESP after 8 WAIT cycles with rsp_err_o=1 and rsp_data_o=0; with the macro off, busy_o stays high indefinitely.
REQ-043 Reset mid-WAIT: rst_n low for 1 cycle at cycle 5 -> all outputs at reset values immediately; a subsequent tie grants requester 0.
